// File: rtl/reset_seq_if.sv
// -----------------------------------------------------------------------------
// reset_seq_if
// Groups the software-reset request and the sequenced reset outputs of
// reset_seq into one bundle. Clock and the asynchronous reset stay plain ports
// on the module itself.
//
// Signals:
//   i_sw_rst      synchronous software reset request, level, active-high
//   o_rst[N_CH]   per-channel reset outputs, active-high, bit 0 releases first
//   o_ready       high once every o_rst bit has been released
//   o_sw_rst_cnt  8-bit saturating software-reset count
//                 (present only when RST_SEQ_CNT_EN is defined)
//
// Modports:
//   slave   the reset sequencer side (drives the outputs)
//   master  the consumer/controller side (drives i_sw_rst)
// -----------------------------------------------------------------------------
interface reset_seq_if #(
    parameter int N_CH = 4
) ();

    logic            i_sw_rst;
    logic [N_CH-1:0] o_rst;
    logic            o_ready;

`ifdef RST_SEQ_CNT_EN
    logic [7:0]      o_sw_rst_cnt;

    modport slave (
        input  i_sw_rst,
        output o_rst,
        output o_ready,
        output o_sw_rst_cnt
    );

    modport master (
        output i_sw_rst,
        input  o_rst,
        input  o_ready,
        input  o_sw_rst_cnt
    );
`else
    modport slave (
        input  i_sw_rst,
        output o_rst,
        output o_ready
    );

    modport master (
        output i_sw_rst,
        input  o_rst,
        input  o_ready
    );
`endif

endinterface

// File: rtl/reset_seq.sv
// -----------------------------------------------------------------------------
// reset_seq
// Parametrised reset synchroniser and sequencer. One asynchronous active-high
// reset asserts all N_CH reset outputs at once; after a synchroniser delay and
// a stretch period the outputs release one at a time in ascending channel
// order, GAP_CYCLES apart. A synchronous software reset request re-runs the
// sequence without touching the synchroniser.
//
// Parameters:
//   N_CH            number of sequenced reset outputs (>=1)
//   SYNC_STAGES     depth of the release synchroniser chain (>=2)
//   STRETCH_CYCLES  cycles all outputs stay asserted after synchronised release
//   GAP_CYCLES      cycles between release of consecutive channels
//
// Ports:
//   i_clk   single clock for the whole block
//   i_rst   asynchronous active-high reset, asserts all outputs without a clock
//   bus     reset_seq_if.slave: i_sw_rst in, o_rst / o_ready out
//
// Optional feature (macro RST_SEQ_CNT_EN):
//   Adds bus.o_sw_rst_cnt, an 8-bit saturating count of software-reset rising
//   edges seen outside HOLD, cleared only by i_rst.
// -----------------------------------------------------------------------------
module reset_seq #(
    parameter int N_CH           = 4,
    parameter int SYNC_STAGES    = 3,
    parameter int STRETCH_CYCLES = 16,
    parameter int GAP_CYCLES     = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    reset_seq_if.slave   bus
);

    localparam int STRETCH_W = $clog2(STRETCH_CYCLES + 1);
    localparam int GAP_W     = $clog2(GAP_CYCLES + 1);
    localparam int IDX_W     = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic [1:0] {
        ST_HOLD,
        ST_STRETCH,
        ST_RELEASE,
        ST_RUN
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [STRETCH_W-1:0]   stretch_cnt_q, stretch_cnt_d;
    logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;
    logic [IDX_W-1:0]       ch_idx_q, ch_idx_d;
    logic [N_CH-1:0]        rst_q, rst_d;
    logic                   ready_q, ready_d;
    logic                   rst_sync;

    // Release synchroniser: set asynchronously by i_rst, zeros shift in from
    // the bottom so the top bit drops SYNC_STAGES edges after i_rst goes low.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], 1'b0};
    end

    assign rst_sync = sync_q[SYNC_STAGES-1];

    // Sequencer next-state logic. A software reset outside HOLD takes priority
    // over everything, including a channel that would release on this edge.
    always_comb begin
        state_d       = state_q;
        stretch_cnt_d = stretch_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        ch_idx_d      = ch_idx_q;
        rst_d         = rst_q;
        ready_d       = ready_q;

        if (state_q != ST_HOLD && bus.i_sw_rst) begin
            state_d       = ST_HOLD;
            stretch_cnt_d = '0;
            gap_cnt_d     = '0;
            ch_idx_d      = '0;
            rst_d         = '1;
            ready_d       = 1'b0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    rst_d         = '1;
                    ready_d       = 1'b0;
                    stretch_cnt_d = '0;
                    gap_cnt_d     = '0;
                    ch_idx_d      = '0;
                    if (!rst_sync && !bus.i_sw_rst) begin
                        state_d = ST_STRETCH;
                    end
                end

                ST_STRETCH: begin
                    if (stretch_cnt_q == STRETCH_W'(STRETCH_CYCLES - 1)) begin
                        stretch_cnt_d = '0;
                        rst_d[0]      = 1'b0;
                        // A single channel has nothing left to sequence.
                        if (N_CH == 1) begin
                            state_d = ST_RUN;
                            ready_d = 1'b1;
                        end else begin
                            state_d   = ST_RELEASE;
                            ch_idx_d  = IDX_W'(1);
                            gap_cnt_d = '0;
                        end
                    end else begin
                        stretch_cnt_d = stretch_cnt_q + STRETCH_W'(1);
                    end
                end

                ST_RELEASE: begin
                    if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
                        gap_cnt_d = '0;
                        // Mask-style clear avoids an out-of-range dynamic
                        // select when N_CH is small.
                        for (int i = 0; i < N_CH; i++) begin
                            if (ch_idx_q == IDX_W'(i)) begin
                                rst_d[i] = 1'b0;
                            end
                        end
                        if (ch_idx_q == IDX_W'(N_CH - 1)) begin
                            state_d  = ST_RUN;
                            ready_d  = 1'b1;
                            ch_idx_d = '0;
                        end else begin
                            ch_idx_d = ch_idx_q + IDX_W'(1);
                        end
                    end else begin
                        gap_cnt_d = gap_cnt_q + GAP_W'(1);
                    end
                end

                ST_RUN: begin
                    rst_d   = '0;
                    ready_d = 1'b1;
                end

                default: begin
                    state_d = ST_HOLD;
                    rst_d   = '1;
                    ready_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_q        <= '1;
            state_q       <= ST_HOLD;
            stretch_cnt_q <= '0;
            gap_cnt_q     <= '0;
            ch_idx_q      <= '0;
            rst_q         <= '1;
            ready_q       <= 1'b0;
        end else begin
            sync_q        <= sync_d;
            state_q       <= state_d;
            stretch_cnt_q <= stretch_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            ch_idx_q      <= ch_idx_d;
            rst_q         <= rst_d;
            ready_q       <= ready_d;
        end
    end

    assign bus.o_rst   = rst_q;
    assign bus.o_ready = ready_q;

`ifdef RST_SEQ_CNT_EN
    logic       sw_prev_q, sw_prev_d;
    logic [7:0] sw_cnt_q, sw_cnt_d;

    // Count rising edges of the request that actually abort a sequence; a
    // request that starts while already in HOLD is not counted.
    always_comb begin
        sw_prev_d = bus.i_sw_rst;
        sw_cnt_d  = sw_cnt_q;
        if (bus.i_sw_rst && !sw_prev_q && state_q != ST_HOLD && sw_cnt_q != 8'hFF) begin
            sw_cnt_d = sw_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sw_prev_q <= 1'b0;
            sw_cnt_q  <= 8'd0;
        end else begin
            sw_prev_q <= sw_prev_d;
            sw_cnt_q  <= sw_cnt_d;
        end
    end

    assign bus.o_sw_rst_cnt = sw_cnt_q;
`endif

endmodule

// File: tb/tb_reset_seq.sv
// -----------------------------------------------------------------------------
// tb_reset_seq
// Self-checking bench for reset_seq. The main instance uses the default
// parameters and is compared every cycle against a timing model: the model
// only remembers when the current sequence started and derives each channel's
// release edge from the stretch/gap rules. A second instance with
// N_CH=1, SYNC_STAGES=2, STRETCH_CYCLES=1, GAP_CYCLES=1 covers the minimal
// configuration. The RST_SEQ_CNT_EN section is compiled only with that macro.
// -----------------------------------------------------------------------------
module tb_reset_seq;

    localparam int N   = 4;
    localparam int S   = 3;
    localparam int ST  = 16;
    localparam int GAP = 4;

    logic i_clk;
    logic i_rst;
    logic rst_b;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int n          = 0;
    int low_cnt    = 0;
    int start_edge = 0;
    bit active     = 1'b0;
    bit prev_sw    = 1'b0;
    int sw_cnt     = 0;

    reset_seq_if #(.N_CH(N)) bus ();
    reset_seq_if #(.N_CH(1)) bus_b ();

    reset_seq #(
        .N_CH(N),
        .SYNC_STAGES(S),
        .STRETCH_CYCLES(ST),
        .GAP_CYCLES(GAP)
    ) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .bus(bus.slave)
    );

    reset_seq #(
        .N_CH(1),
        .SYNC_STAGES(2),
        .STRETCH_CYCLES(1),
        .GAP_CYCLES(1)
    ) dut_b (
        .i_clk(i_clk),
        .i_rst(rst_b),
        .bus(bus_b.slave)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Channel k releases STRETCH + k*GAP edges after the edge that left HOLD.
    function automatic logic [N-1:0] expRst();
        logic [N-1:0] r;
        for (int k = 0; k < N; k++) begin
            r[k] = !(active && (n >= start_edge + ST + GAP * k));
        end
        return r;
    endfunction

    function automatic logic expReady();
        return active && (n >= start_edge + ST + GAP * (N - 1));
    endfunction

    task automatic modelAsyncReset();
        active  = 1'b0;
        low_cnt = 0;
        prev_sw = 1'b0;
        sw_cnt  = 0;
    endtask

    task automatic modelEdge(input logic sw, input logic rst);
        bit synced;
        n++;
        if (rst) begin
            modelAsyncReset();
        end else begin
            synced = (low_cnt >= S);
            if (active && sw && !prev_sw && sw_cnt < 255) sw_cnt++;
            if (!active) begin
                if (synced && !sw) begin
                    active     = 1'b1;
                    start_edge = n;
                end
            end else if (sw) begin
                active = 1'b0;
            end
            prev_sw = sw;
            if (low_cnt < 1000) low_cnt++;
        end
    endtask

    task automatic compareModel(input string pfx);
        checkOutput({pfx, "_rst"}, 32'(bus.o_rst), 32'(expRst()));
        checkOutput({pfx, "_ready"}, 32'(bus.o_ready), 32'(expReady()));
`ifdef RST_SEQ_CNT_EN
        checkOutput({pfx, "_cnt"}, 32'(bus.o_sw_rst_cnt), 32'(sw_cnt));
`endif
    endtask

    // Called at a falling edge: drive inputs, advance one rising edge, then
    // compare on the following falling edge.
    task automatic applyStimulus(input logic sw, input logic rst);
        bus.i_sw_rst = sw;
        i_rst        = rst;
        if (rst) modelAsyncReset();
        #1;
        if (rst) compareModel("async");
        @(posedge i_clk);
        modelEdge(sw, rst);
        @(negedge i_clk);
        compareModel("seq");
    endtask

    function automatic logic [N-1:0] pwrRstExp(input int e);
        if (e < 20) return 4'b1111;
        if (e < 24) return 4'b1110;
        if (e < 28) return 4'b1100;
        if (e < 32) return 4'b1000;
        return 4'b0000;
    endfunction

    function automatic logic [N-1:0] swRstExp(input int j);
        if (j < 17) return 4'b1111;
        if (j < 21) return 4'b1110;
        if (j < 25) return 4'b1100;
        if (j < 29) return 4'b1000;
        return 4'b0000;
    endfunction

    initial begin
        i_rst           = 1'b1;
        rst_b           = 1'b1;
        bus.i_sw_rst    = 1'b0;
        bus_b.i_sw_rst  = 1'b0;
        modelAsyncReset();
        #1;
        checkOutput("reset_rst", 32'(bus.o_rst), 32'h0000000F);
        checkOutput("reset_ready", 32'(bus.o_ready), 32'h0);
        checkOutput("reset_b_rst", 32'(bus_b.o_rst), 32'h1);
        checkOutput("reset_b_ready", 32'(bus_b.o_ready), 32'h0);

        $display("[TB] power-on sequence");
        repeat (5) applyStimulus(1'b0, 1'b1);
        for (int e = 1; e <= 40; e++) begin
            applyStimulus(1'b0, 1'b0);
            checkOutput("pwr_rst", 32'(bus.o_rst), 32'(pwrRstExp(e)));
            checkOutput("pwr_ready", 32'(bus.o_ready), 32'(e >= 32));
        end

        $display("[TB] async reset from RUN");
        bus.i_sw_rst = 1'b0;
        i_rst        = 1'b1;
        modelAsyncReset();
        #1;
        checkOutput("async_now_rst", 32'(bus.o_rst), 32'h0000000F);
        checkOutput("async_now_ready", 32'(bus.o_ready), 32'h0);
        applyStimulus(1'b0, 1'b1);
        for (int e = 1; e <= 40; e++) begin
            applyStimulus(1'b0, 1'b0);
            checkOutput("rerun_rst", 32'(bus.o_rst), 32'(pwrRstExp(e)));
            checkOutput("rerun_ready", 32'(bus.o_ready), 32'(e >= 32));
        end

        $display("[TB] software reset from RUN");
        repeat (3) begin
            applyStimulus(1'b1, 1'b0);
            checkOutput("sw_hold_rst", 32'(bus.o_rst), 32'h0000000F);
        end
        for (int j = 1; j <= 32; j++) begin
            applyStimulus(1'b0, 1'b0);
            checkOutput("sw_rel_rst", 32'(bus.o_rst), 32'(swRstExp(j)));
            checkOutput("sw_rel_ready", 32'(bus.o_ready), 32'(j >= 29));
        end

        $display("[TB] abort mid-release");
        applyStimulus(1'b1, 1'b0);
        for (int j = 1; j <= 24; j++) applyStimulus(1'b0, 1'b0);
        checkOutput("pre_abort_rst", 32'(bus.o_rst), 32'h0000000C);
        applyStimulus(1'b1, 1'b0);
        checkOutput("abort_rst", 32'(bus.o_rst), 32'h0000000F);
        repeat (2) begin
            applyStimulus(1'b1, 1'b0);
            checkOutput("abort_hold_rst", 32'(bus.o_rst), 32'h0000000F);
        end
        for (int j = 1; j <= 32; j++) begin
            applyStimulus(1'b0, 1'b0);
            checkOutput("abort_rel_rst", 32'(bus.o_rst), 32'(swRstExp(j)));
        end

        $display("[TB] random stimulus");
        repeat (600) begin
            applyStimulus(1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 199) == 0));
        end

        $display("[TB] minimal configuration");
        rst_b = 1'b1;
        applyStimulus(1'b0, 1'b0);
        checkOutput("min_reset_rst", 32'(bus_b.o_rst), 32'h1);
        rst_b = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            applyStimulus(1'b0, 1'b0);
            checkOutput("min_rst", 32'(bus_b.o_rst), 32'(e < 4));
            checkOutput("min_ready", 32'(bus_b.o_ready), 32'(e >= 4));
        end

`ifdef RST_SEQ_CNT_EN
        $display("[TB] software reset counter");
        applyStimulus(1'b0, 1'b1);
        repeat (40) applyStimulus(1'b0, 1'b0);
        checkOutput("cnt_start", 32'(bus.o_sw_rst_cnt), 32'h0);
        checkOutput("cnt_start_ready", 32'(bus.o_ready), 32'h1);
        for (int r = 0; r < 300; r++) begin
            applyStimulus(1'b1, 1'b0);
            repeat (29) applyStimulus(1'b0, 1'b0);
        end
        checkOutput("cnt_sat", 32'(bus.o_sw_rst_cnt), 32'd255);
        bus.i_sw_rst = 1'b0;
        i_rst        = 1'b1;
        modelAsyncReset();
        #1;
        checkOutput("cnt_clear", 32'(bus.o_sw_rst_cnt), 32'h0);
        applyStimulus(1'b0, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reset_seq.md
Name: reset_seq

Overview:
- Parametrised reset synchroniser and sequencer. It generalises the single-output async-assert/sync-release reset synchroniser.
- Takes one asynchronous active-high reset and drives N_CH active-high reset outputs. Outputs assert together immediately and release one by one, in channel order, after a synchronisation and stretch period.
- Also accepts a synchronous software reset request that re-runs the sequence.
- Placed at the top of each clock domain to order the release of dependent subsystems (e.g. PHY, then MAC, then fabric).

Parameters:
- N_CH, 4, number of sequenced reset outputs (>=1).
- SYNC_STAGES, 3, depth of the release synchroniser flop chain (>=2).
- STRETCH_CYCLES, 16, minimum cycles all outputs stay asserted after synchronised release (>=1).
- GAP_CYCLES, 4, cycles between release of consecutive channels (>=1).

Ports:
- i_clk  in  1  single clock for the whole block.
- i_rst  in  1  reset, asynchronous, active-high; asserts all outputs without a clock.
- i_sw_rst  in  1  synchronous software reset request, level, active-high.
- o_rst  out  N_CH  per-channel reset, active-high; bit 0 releases first.
- o_ready  out  1  high when every o_rst bit is released.

Behaviour:
- Interface (already decided): one clock i_clk; reset i_rst is asynchronous and active-high.
- Reset values (i_rst=1): synchroniser chain all 1; o_rst all 1; o_ready 0; FSM in HOLD; all counters 0. This takes effect asynchronously, with no clock edge needed.
- Synchroniser: SYNC_STAGES flops, async-set by i_rst, shifting in 0. Its output rst_sync falls at the SYNC_STAGES-th rising edge that samples i_rst low.
- FSM states:
  - HOLD: all o_rst=1, o_ready=0. Moves to STRETCH at the first edge where rst_sync=0 and i_sw_rst=0.
  - STRETCH: counter increments from 0. After STRETCH_CYCLES cycles, moves to RELEASE and clears o_rst[0] on the same edge.
  - RELEASE: gap counter counts GAP_CYCLES cycles, then clears the next o_rst bit, in ascending index order. Moves to RUN on the edge that clears o_rst[N_CH-1].
  - RUN: o_rst all 0, o_ready=1. Stays until a reset event.
- Release timing: edge 1 is the first edge with i_rst low.
  - o_rst[0] falls at edge SYNC_STAGES+1+STRETCH_CYCLES.
  - o_rst[k] falls GAP_CYCLES*k edges later.
  - o_ready rises on the same edge as o_rst[N_CH-1] falls.
  - Defaults: o_rst[0] falls at edge 20, o_rst[1] at 24, o_rst[2] at 28, o_rst[3] and o_ready at 32.
- N_CH=1: RELEASE is skipped. o_rst[0] and o_ready change on the same edge.
- Outputs only move in sequence:
  - Once released, an o_rst bit stays 0 until a reset event.
  - Outputs never release out of order.
  - No glitch: o_rst and o_ready come straight from flops, never from combinational logic.
- i_sw_rst=1 sampled in STRETCH, RELEASE or RUN:
  - Next edge: all o_rst=1, o_ready=0, FSM to HOLD, counters cleared.
  - The synchroniser is not affected.
  - The FSM stays in HOLD while i_sw_rst=1. Once it is sampled 0, the sequence restarts at STRETCH: o_rst[0] falls STRETCH_CYCLES+1 edges after the first edge that samples i_sw_rst low.
- Mid-sequence i_rst assertion: all outputs return to 1 immediately and asynchronously. The full sequence restarts, including the synchroniser delay.
- Simultaneous events: i_sw_rst=1 on the same edge a channel would release overrides it; that channel stays asserted.
- Counter widths: $clog2(STRETCH_CYCLES+1) and $clog2(GAP_CYCLES+1). Counters never wrap; they clear on each state or channel transition.

Optional Feature:
- Macro: RST_SEQ_CNT_EN.
- Defined:
  - Adds output port o_sw_rst_cnt (8 bits).
  - It increments once per i_sw_rst rising edge that is sampled while not in HOLD.
  - Saturates at 255.
  - Cleared only by i_rst, asynchronously to 0.
- Undefined: the port and its counter are absent. All other behaviour is identical.

Test Plan:
- Power-on: i_rst=1 for 5 cycles, then 0, with defaults -> o_rst=4'b1111 through edge 19; bit 0 falls at edge 20, bit 1 at 24, bit 2 at 28, bit 3 and o_ready at 32.
- Async assert: in RUN, raise i_rst between clock edges -> o_rst=4'b1111 and o_ready=0 before the next edge; release timing repeats exactly as in power-on.
- Software reset in RUN: i_sw_rst=1 for 3 cycles -> all o_rst=1 on the next edge; o_rst[0] falls 17 edges after i_sw_rst is first sampled 0; o_ready follows 12 edges later.
- Abort mid-release: assert i_sw_rst on the edge o_rst[2] would fall (o_rst=4'b1100) -> o_rst=4'b1111 next edge; o_rst[2] never falls in that pass.
- Parameter sweep: N_CH=1, SYNC_STAGES=2, STRETCH_CYCLES=1, GAP_CYCLES=1 -> o_rst[0] and o_ready change together at edge 4.
- RST_SEQ_CNT_EN: 300 software resets issued from RUN -> o_sw_rst_cnt saturates at 255; a single i_rst pulse returns it to 0.
